// File: rtl/aead_pkg.sv
// Shared types and default sizing for the AEAD stream sequencer.
package aead_pkg;
   localparam int unsigned W_DEF   = 128;
   localparam int unsigned WPB_DEF = 4;
   localparam int unsigned CW_DEF  = 32;
   localparam int unsigned TAG_W   = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_DRAIN,
      S_FINAL,
      S_TAG
   } state_e;
endpackage

// File: rtl/aead_stream_sequencer_if.sv
// Word stream with valid/ready handshake and end-of-message marker.
interface aead_stream_sequencer_if
   import aead_pkg::*;
#(
   parameter int unsigned W = W_DEF
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         last;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/aead_word_packer.sv
// WPB-entry word bank: filled word by word from the stream, reloaded whole from
// the core, then read back in index order.
module aead_word_packer
   import aead_pkg::*;
#(
   parameter int unsigned W   = W_DEF,
   parameter int unsigned WPB = WPB_DEF,
   parameter int unsigned IW  = $clog2(WPB + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [W-1:0]     wr_data,
   input  logic             load_en,
   input  logic [WPB*W-1:0] load_data,
   input  logic             rd_adv,
   output logic [WPB*W-1:0] blk,
   output logic [IW-1:0]    cnt,
   output logic [IW-1:0]    rd_idx
);
   localparam int unsigned AW = (WPB > 1) ? $clog2(WPB) : 1;

   logic [W-1:0]  bank_q [WPB];
   logic [W-1:0]  bank_d [WPB];
   logic [IW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] rd_q, rd_d;

   // Clear wins over load; the write count survives a load so drain knows n.
   always_comb begin
      bank_d = bank_q;
      cnt_d  = cnt_q;
      rd_d   = rd_q;
      if (clr) begin
         for (int unsigned k = 0; k < WPB; k++) bank_d[k] = '0;
         cnt_d = '0;
         rd_d  = '0;
      end else if (load_en) begin
         for (int unsigned k = 0; k < WPB; k++) bank_d[k] = load_data[k*W +: W];
         rd_d = '0;
      end else begin
         if (wr_en && (cnt_q < IW'(WPB))) begin
            bank_d[AW'(cnt_q)] = wr_data;
            cnt_d              = cnt_q + IW'(1);
         end
         if (rd_adv) rd_d = rd_q + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k < WPB; k++) bank_q[k] <= '0;
         cnt_q <= '0;
         rd_q  <= '0;
      end else begin
         bank_q <= bank_d;
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
      end
   end

   always_comb begin
      blk = '0;
      for (int unsigned k = 0; k < WPB; k++) blk[k*W +: W] = bank_q[k];
   end

   assign cnt    = cnt_q;
   assign rd_idx = rd_q;
endmodule

// File: rtl/aead_stream_sequencer.sv
// Sequences a word stream through a block-oriented AEAD core: packs words into
// blocks, issues them, drains results and collects the final tag.
module aead_stream_sequencer
   import aead_pkg::*;
#(
   parameter int unsigned W   = W_DEF,
   parameter int unsigned WPB = WPB_DEF,
   parameter int unsigned CW  = CW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    encdec,
   aead_stream_sequencer_if.slave  s,
   aead_stream_sequencer_if.master m,
   output logic                    core_init,
   output logic                    core_next,
   output logic                    core_done,
   output logic                    core_encdec,
   output logic [WPB*W-1:0]        core_data_in,
   input  logic                    core_ready,
   input  logic                    core_valid,
   input  logic                    core_tag_ok,
   input  logic [WPB*W-1:0]        core_data_out,
   input  logic [TAG_W-1:0]        core_tag,
   output logic                    busy,
   output logic                    tag_valid,
   output logic [TAG_W-1:0]        tag_out,
   output logic [CW-1:0]           blk_cycles,
   output logic [CW-1:0]           total_cycles
);
   localparam int unsigned IW = $clog2(WPB + 1);
   localparam int unsigned AW = (WPB > 1) ? $clog2(WPB) : 1;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   state_e             state_q, state_d;
   logic               encdec_q, encdec_d, last_blk_q, last_blk_d;
   logic               core_init_q, core_init_d, core_next_q, core_next_d;
   logic               core_done_q, core_done_d, busy_q, busy_d;
   logic               s_ready_q, s_ready_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic               tag_valid_q, tag_valid_d;
   logic [W-1:0]       m_data_q, m_data_d;
   logic [TAG_W-1:0]   tag_out_q, tag_out_d;
   logic [CW-1:0]      blk_cycles_q, blk_cycles_d, total_cycles_q, total_cycles_d;
   logic [CW-1:0]      bcnt_q, bcnt_d, tcnt_q, tcnt_d;

   logic               pk_clr, pk_wr, pk_load, pk_adv;
   logic [WPB*W-1:0]   pk_blk;
   logic [IW-1:0]      pk_cnt, pk_rd;
   logic [AW-1:0]      nxt;
   logic               s_fire, m_fire, fill_done, drain_end;

   aead_word_packer #(.W(W), .WPB(WPB), .IW(IW)) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (pk_clr),
      .wr_en     (pk_wr),
      .wr_data   (s.data),
      .load_en   (pk_load),
      .load_data (core_data_out),
      .rd_adv    (pk_adv),
      .blk       (pk_blk),
      .cnt       (pk_cnt),
      .rd_idx    (pk_rd)
   );

   assign s_fire    = s.valid && s_ready_q;
   assign m_fire    = m_valid_q && m.ready;
   assign fill_done = s_fire && ((pk_cnt == IW'(WPB - 1)) || s.last);
   assign drain_end = m_fire && (pk_rd == (pk_cnt - IW'(1)));
   assign nxt       = AW'(pk_rd + IW'(1));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)       state_d = S_INIT;
         S_INIT:  if (core_ready)  state_d = S_FILL;
         S_FILL:  if (fill_done)   state_d = S_ISSUE;
         S_ISSUE:                  state_d = S_WAIT;
         S_WAIT:  if (core_valid)  state_d = S_DRAIN;
         S_DRAIN: if (drain_end)   state_d = last_blk_q ? S_FINAL : S_FILL;
         S_FINAL:                  state_d = S_TAG;
         S_TAG:   if (core_tag_ok) state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with state_q.
   always_comb begin
      encdec_d       = encdec_q;
      last_blk_d     = last_blk_q;
      core_init_d    = (state_q == S_IDLE) && (state_d == S_INIT);
      core_next_d    = (state_d == S_ISSUE);
      core_done_d    = (state_d == S_FINAL);
      busy_d         = (state_d != S_IDLE);
      s_ready_d      = (state_d == S_FILL);
      m_valid_d      = (state_d == S_DRAIN);
      m_data_d       = m_data_q;
      m_last_d       = m_last_q;
      tag_valid_d    = 1'b0;
      tag_out_d      = tag_out_q;
      blk_cycles_d   = blk_cycles_q;
      total_cycles_d = total_cycles_q;
      bcnt_d         = bcnt_q;
      tcnt_d         = (state_q != S_IDLE) ? sat_inc(tcnt_q) : tcnt_q;
      pk_clr         = 1'b0;
      pk_wr          = s_fire;
      pk_load        = 1'b0;
      pk_adv         = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            encdec_d = encdec;
            tcnt_d   = CW'(1);
            pk_clr   = 1'b1;
         end
         S_FILL: if (fill_done) last_blk_d = s.last;
         S_ISSUE: bcnt_d = CW'(1);
         S_WAIT: begin
            bcnt_d = sat_inc(bcnt_q);
            if (core_valid) begin
               pk_load      = 1'b1;
               blk_cycles_d = bcnt_q;
               m_data_d     = core_data_out[W-1:0];
               m_last_d     = last_blk_q && (pk_cnt == IW'(1));
            end
         end
         S_DRAIN: if (m_fire) begin
            if (drain_end) begin
               m_data_d = '0;
               m_last_d = 1'b0;
               pk_clr   = !last_blk_q;
            end else begin
               pk_adv   = 1'b1;
               m_data_d = pk_blk[32'(nxt) * W +: W];
               m_last_d = last_blk_q && ((pk_rd + IW'(2)) == pk_cnt);
            end
         end
         S_TAG: if (core_tag_ok) begin
            tag_out_d      = core_tag;
            tag_valid_d    = 1'b1;
            total_cycles_d = tcnt_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         encdec_q       <= 1'b0;
         last_blk_q     <= 1'b0;
         core_init_q    <= 1'b0;
         core_next_q    <= 1'b0;
         core_done_q    <= 1'b0;
         busy_q         <= 1'b0;
         s_ready_q      <= 1'b0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_last_q       <= 1'b0;
         tag_valid_q    <= 1'b0;
         tag_out_q      <= '0;
         blk_cycles_q   <= '0;
         total_cycles_q <= '0;
         bcnt_q         <= '0;
         tcnt_q         <= '0;
      end else begin
         encdec_q       <= encdec_d;
         last_blk_q     <= last_blk_d;
         core_init_q    <= core_init_d;
         core_next_q    <= core_next_d;
         core_done_q    <= core_done_d;
         busy_q         <= busy_d;
         s_ready_q      <= s_ready_d;
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_last_q       <= m_last_d;
         tag_valid_q    <= tag_valid_d;
         tag_out_q      <= tag_out_d;
         blk_cycles_q   <= blk_cycles_d;
         total_cycles_q <= total_cycles_d;
         bcnt_q         <= bcnt_d;
         tcnt_q         <= tcnt_d;
      end
   end

   assign s.ready      = s_ready_q;
   assign m.valid      = m_valid_q;
   assign m.data       = m_data_q;
   assign m.last       = m_last_q;
   assign core_init    = core_init_q;
   assign core_next    = core_next_q;
   assign core_done    = core_done_q;
   assign core_encdec  = encdec_q;
   assign core_data_in = pk_blk;
   assign busy         = busy_q;
   assign tag_valid    = tag_valid_q;
   assign tag_out      = tag_out_q;
   assign blk_cycles   = blk_cycles_q;
   assign total_cycles = total_cycles_q;
endmodule

// File: tb/tb_aead_stream_sequencer.sv
// Directed bench for aead_stream_sequencer; a second instance with 4-bit counters
// shares all inputs to exercise saturation.
module tb_aead_stream_sequencer;
   import aead_pkg::*;

   localparam int unsigned W   = 128;
   localparam int unsigned WPB = 4;
   localparam int unsigned CW  = 32;
   localparam int unsigned CWS = 4;
   localparam logic [W-1:0]     MASK_W   = {4{32'h0f0f0f0f}};
   localparam logic [WPB*W-1:0] MASK_BLK = {WPB{MASK_W}};
   localparam logic [W-1:0]     CAFE     = 128'hcafebabedeadbeefcafebabedeadbeef;
   localparam logic [W-1:0]     CAFE_X   = 128'hc5f1b5b1d1a2b1e0c5f1b5b1d1a2b1e0;

   logic clk = 1'b0;
   logic rst, start, encdec;
   logic core_ready, core_valid, core_tag_ok;
   logic [WPB*W-1:0] core_data_out, blk_in;
   logic [TAG_W-1:0] core_tag;
   logic core_init, core_next, core_done, core_encdec, busy, tag_valid;
   logic [WPB*W-1:0] core_data_in;
   logic [TAG_W-1:0] tag_out;
   logic [CW-1:0] blk_cycles, total_cycles;
   logic d2_init, d2_next, d2_done, d2_encdec, d2_busy, d2_tag_valid;
   logic [WPB*W-1:0] d2_data_in;
   logic [TAG_W-1:0] d2_tag_out;
   logic [CWS-1:0] d2_blk_cycles, d2_total_cycles;

   int vectors = 0;
   int miscompares = 0;
   int lat = 3;
   int lcnt;
   logic pend, done_d;
   int n_init, n_tag;
   logic [W-1:0] in_w [16];
   logic [W-1:0] exp_w [16];
   logic [W-1:0] out_q [$];
   logic out_last_q [$];
   logic [WPB*W-1:0] blk_q [$];

   always #5 clk = ~clk;

   aead_stream_sequencer_if #(.W(W)) s_if ();
   aead_stream_sequencer_if #(.W(W)) m_if ();
   aead_stream_sequencer_if #(.W(W)) s2_if ();
   aead_stream_sequencer_if #(.W(W)) m2_if ();

   assign s2_if.valid = s_if.valid;
   assign s2_if.data  = s_if.data;
   assign s2_if.last  = s_if.last;
   assign m2_if.ready = m_if.ready;

   aead_stream_sequencer #(.W(W), .WPB(WPB), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .encdec(encdec), .s(s_if), .m(m_if),
      .core_init(core_init), .core_next(core_next), .core_done(core_done),
      .core_encdec(core_encdec), .core_data_in(core_data_in), .core_ready(core_ready),
      .core_valid(core_valid), .core_tag_ok(core_tag_ok), .core_data_out(core_data_out),
      .core_tag(core_tag), .busy(busy), .tag_valid(tag_valid), .tag_out(tag_out),
      .blk_cycles(blk_cycles), .total_cycles(total_cycles)
   );

   aead_stream_sequencer #(.W(W), .WPB(WPB), .CW(CWS)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .encdec(encdec), .s(s2_if), .m(m2_if),
      .core_init(d2_init), .core_next(d2_next), .core_done(d2_done),
      .core_encdec(d2_encdec), .core_data_in(d2_data_in), .core_ready(core_ready),
      .core_valid(core_valid), .core_tag_ok(core_tag_ok), .core_data_out(core_data_out),
      .core_tag(core_tag), .busy(d2_busy), .tag_valid(d2_tag_valid), .tag_out(d2_tag_out),
      .blk_cycles(d2_blk_cycles), .total_cycles(d2_total_cycles)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Core model: result = block ^ mask, lat cycles after core_next; tag_ok 2 cycles after core_done.
   always @(posedge clk) begin
      if (!rst) begin
         pend <= 1'b0; lcnt <= 0; core_valid <= 1'b0; blk_in <= '0;
         done_d <= 1'b0; core_tag_ok <= 1'b0;
      end else begin
         core_valid  <= 1'b0;
         done_d      <= core_done;
         core_tag_ok <= done_d;
         if (core_next) begin
            blk_in <= core_data_in;
            lcnt   <= 1;
            pend   <= (lat != 1);
            core_valid <= (lat == 1);
         end else if (pend) begin
            lcnt <= lcnt + 1;
            if (lcnt + 1 == lat) begin
               core_valid <= 1'b1;
               pend       <= 1'b0;
            end
         end
      end
   end
   assign core_data_out = blk_in ^ MASK_BLK;

   // Passive monitor; also checks a stalled output word holds the expected value.
   always @(negedge clk) begin
      if (rst) begin
         if (core_init) n_init++;
         if (tag_valid) n_tag++;
         if (core_next) blk_q.push_back(core_data_in);
         if (m_if.valid && m_if.ready) begin
            out_q.push_back(m_if.data);
            out_last_q.push_back(m_if.last);
         end else if (m_if.valid && out_q.size() < 16) begin
            chk("stall_hold", m_if.data, exp_w[out_q.size()]);
         end
      end
   end

   task automatic clear_mon();
      out_q.delete(); out_last_q.delete(); blk_q.delete();
      n_init = 0; n_tag = 0;
   endtask

   task automatic pulse_start(input logic ed);
      encdec = ed; start = 1'b1;
      @(negedge clk);
      start = 1'b0; encdec = ~ed;
   endtask

   task automatic send_words(input int n);
      for (int i = 0; i < n; i++) begin
         s_if.valid = 1'b1; s_if.data = in_w[i]; s_if.last = (i == n - 1);
         for (int k = 0; k < 200 && !s_if.ready; k++) @(negedge clk);
         chk("s_ready_wait", W'(s_if.ready), W'(1));
         @(negedge clk);
      end
      s_if.valid = 1'b0; s_if.last = 1'b0;
   endtask

   task automatic wait_tag();
      for (int k = 0; k < 2000 && n_tag == 0; k++) @(negedge clk);
      @(negedge clk);
      chk("tag_pulses", W'(n_tag), W'(1));
   endtask

   task automatic check_out(input int n);
      chk("out_count", W'(out_q.size()), W'(n));
      for (int i = 0; i < n; i++) begin
         chk("out_data", out_q[i], exp_w[i]);
         chk("out_last", W'(out_last_q[i]), W'(i == n - 1));
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; start = 1'b0; encdec = 1'b0; core_ready = 1'b1; core_tag = '0;
      s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_s_ready", W'(s_if.ready), W'(0));
      chk("rst_m_valid", W'(m_if.valid), W'(0));
      chk("rst_tag_out", tag_out, W'(0));
      chk("rst_total", W'(total_cycles), W'(0));
      rst = 1'b1;
      @(negedge clk);

      // 8 identical words, two full blocks
      for (int i = 0; i < 8; i++) begin in_w[i] = CAFE; exp_w[i] = CAFE_X; end
      clear_mon(); lat = 3; core_tag = 128'h00112233445566778899aabbccddeeff;
      pulse_start(1'b1);
      send_words(8);
      wait_tag();
      chk("a_inits", W'(n_init), W'(1));
      chk("a_nexts", W'(blk_q.size()), W'(2));
      for (int k = 0; k < 4; k++) chk("a_blk0_word", blk_q[0][k*W +: W], CAFE);
      check_out(8);
      chk("a_tag_out", tag_out, 128'h00112233445566778899aabbccddeeff);
      chk("a_encdec_hold", W'(core_encdec), W'(1));
      chk("a_blk_cycles", W'(blk_cycles), W'(3));
      chk("a_total", W'(total_cycles), W'(28));
      chk("a_total_sat", W'(d2_total_cycles), W'(15));

      // 6 words: partial second block, slow core
      for (int i = 0; i < 6; i++) begin
         in_w[i] = {4{32'h10000000 | 32'(i)}}; exp_w[i] = in_w[i] ^ MASK_W;
      end
      clear_mon(); lat = 20; core_tag = 128'hfeedface0000000000000000deadc0de;
      pulse_start(1'b0);
      send_words(6);
      wait_tag();
      chk("b_nexts", W'(blk_q.size()), W'(2));
      chk("b_blk1_w0", blk_q[1][0*W +: W], in_w[4]);
      chk("b_blk1_w1", blk_q[1][1*W +: W], in_w[5]);
      chk("b_blk1_w2", blk_q[1][2*W +: W], W'(0));
      chk("b_blk1_w3", blk_q[1][3*W +: W], W'(0));
      check_out(6);
      chk("b_tag_out", tag_out, 128'hfeedface0000000000000000deadc0de);
      chk("b_blk_cycles", W'(blk_cycles), W'(20));
      chk("b_blk_sat", W'(d2_blk_cycles), W'(15));
      chk("b_total", W'(total_cycles), W'(58));
      chk("b_total_sat", W'(d2_total_cycles), W'(15));

      // 4 words with a 5-cycle output stall after the first word
      for (int i = 0; i < 4; i++) begin
         in_w[i] = {4{32'h30000000 | 32'(i)}}; exp_w[i] = in_w[i] ^ MASK_W;
      end
      clear_mon(); lat = 3;
      pulse_start(1'b0);
      fork
         send_words(4);
         begin
            for (int k = 0; k < 200 && out_q.size() < 1; k++) @(posedge clk);
            #1 m_if.ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 m_if.ready = 1'b1;
         end
      join
      wait_tag();
      check_out(4);
      chk("c_total", W'(total_cycles), W'(21));

      // reset while waiting on the core, then a clean 4-word message
      for (int i = 0; i < 4; i++) in_w[i] = {4{32'h40000000 | 32'(i)}};
      clear_mon(); lat = 20;
      pulse_start(1'b0);
      send_words(4);
      for (int k = 0; k < 100 && blk_q.size() < 1; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("d_rst_busy", W'(busy), W'(0));
      chk("d_rst_m_valid", W'(m_if.valid), W'(0));
      chk("d_rst_blk", W'(blk_cycles), W'(0));
      chk("d_rst_total", W'(total_cycles), W'(0));
      chk("d_rst_tag_out", tag_out, W'(0));
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         in_w[i] = {4{32'h50000000 | 32'(i)}}; exp_w[i] = in_w[i] ^ MASK_W;
      end
      clear_mon(); lat = 3; core_tag = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
      pulse_start(1'b1);
      send_words(4);
      wait_tag();
      check_out(4);
      chk("d_tag_out", tag_out, 128'h5555aaaa5555aaaa5555aaaa5555aaaa);
      chk("d_total", W'(total_cycles), W'(16));

      // start pulsed mid-FILL must not restart or change mode
      for (int i = 0; i < 8; i++) begin
         in_w[i] = {4{32'h20000000 | 32'(i)}}; exp_w[i] = in_w[i] ^ MASK_W;
      end
      clear_mon(); lat = 3;
      pulse_start(1'b1);
      fork
         send_words(8);
         begin
            repeat (3) @(negedge clk);
            encdec = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      wait_tag();
      chk("e_inits", W'(n_init), W'(1));
      check_out(8);
      chk("e_encdec_hold", W'(core_encdec), W'(1));
      chk("e_total", W'(total_cycles), W'(28));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
